// File: rtl/fold_accumulator.sv
// fold_accumulator
// Reduces a WIDTH-element vector to a single value with LANES adders that are
// reused layer by layer, then adds each reduced vector into a running burst
// accumulator. A burst ends on a vector flagged with in_last, after which the
// total is presented on sum with a valid/ready handshake. Adds either wrap or
// saturate (SAT), and any signed overflow in the burst raises a sticky ovf.

module fold_accumulator #(
    parameter int WIDTH = 16,
    parameter int DATAW = 32,
    parameter int LANES = 4,
    parameter int SAT   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [DATAW*WIDTH-1:0] vals,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATAW-1:0]       sum,
    output logic [15:0]            out_count,
    output logic                   ovf,
    output logic                   busy
);

    // Index width for the register file and width of the active-count / cycle counters.
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int NW = IW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic [DATAW-1:0]  r_r      [WIDTH];
    logic [DATAW-1:0]  r_next_s [WIDTH];
    logic [DATAW-1:0]  acc_r;
    logic [DATAW-1:0]  sum_r;
    logic [15:0]       out_count_r;
    logic              ovf_r;
    logic              out_valid_r;
    logic              last_r;

    // n_r is the number of live elements in the current layer, cyc_r the cycle within it.
    logic [NW-1:0]     n_r;
    logic [NW-1:0]     cyc_r;
    logic [NW-1:0]     pairs_s;
    logic              layer_end_s;
    logic              fold_done_s;
    logic              fold_ovf_s;
    logic [DATAW:0]    acc_add_s;

    // Adds two elements; returns {overflow, result}. The result clamps when SAT is set.
    function automatic logic [DATAW:0] add_op(input logic [DATAW-1:0] a,
                                              input logic [DATAW-1:0] b);
        logic [DATAW-1:0] raw_s;
        logic [DATAW-1:0] clamp_s;
        logic             v_s;
        raw_s   = a + b;
        v_s     = (a[DATAW-1] == b[DATAW-1]) && (raw_s[DATAW-1] != a[DATAW-1]);
        clamp_s = a[DATAW-1] ? {1'b1, {(DATAW-1){1'b0}}} : {1'b0, {(DATAW-1){1'b1}}};
        return {v_s, ((SAT != 32'sd0) && v_s) ? clamp_s : raw_s};
    endfunction

    assign pairs_s     = n_r >> 1'b1;
    assign fold_done_s = layer_end_s && (pairs_s == {{(NW-1){1'b0}}, 1'b1});
    assign acc_add_s   = add_op(acc_r, r_r[0]);

    assign in_ready  = en & (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign out_count = out_count_r;
    assign ovf       = ovf_r;

    // Flags the final cycle of the current layer: this cycle's lanes cover the last pair.
    always_comb begin
        layer_end_s = 1'b0;
        if ((int'(cyc_r) + 32'sd1) * LANES >= int'(pairs_s)) begin
            layer_end_s = 1'b1;
        end else begin
            layer_end_s = 1'b0;
        end
    end

    // One layer cycle of the fold: lane j sums pair k into slot k. Writes only land on
    // slots below every pair still to be read, so the update can be done in place.
    always_comb begin : fold_lanes
        int               k_s;
        logic [DATAW:0]   lane_s;
        logic [IW-1:0]    dst_idx_s;
        logic [IW-1:0]    lo_idx_s;
        logic [IW-1:0]    hi_idx_s;
        k_s        = 32'sd0;
        lane_s     = '0;
        dst_idx_s  = '0;
        lo_idx_s   = '0;
        hi_idx_s   = '0;
        r_next_s   = r_r;
        fold_ovf_s = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            k_s = int'(cyc_r) * LANES + j;
            if (k_s < int'(pairs_s)) begin
                dst_idx_s           = IW'(k_s);
                lo_idx_s            = IW'(32'sd2 * k_s);
                hi_idx_s            = IW'(32'sd2 * k_s + 32'sd1);
                lane_s              = add_op(r_r[lo_idx_s], r_r[hi_idx_s]);
                r_next_s[dst_idx_s] = lane_s[DATAW-1:0];
                fold_ovf_s          = fold_ovf_s | lane_s[DATAW];
            end else begin
                lane_s = '0;
            end
        end
    end

    // Next-state selection for the IDLE -> FOLD -> ACC -> (IDLE | DONE) sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_next_s = FOLD;
                else          state_next_s = IDLE;
            end
            FOLD: begin
                if (fold_done_s) state_next_s = ACC;
                else             state_next_s = FOLD;
            end
            ACC: begin
                if (last_r) state_next_s = DONE;
                else        state_next_s = IDLE;
            end
            DONE: begin
                if (out_ready) state_next_s = IDLE;
                else           state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register; advances only on enabled edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else if (en) begin
            state_r <= state_next_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Datapath: register file, fold counters, accumulator and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_r[i] <= '0;
            end
            acc_r       <= '0;
            sum_r       <= '0;
            out_count_r <= 16'd0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
            n_r         <= '0;
            cyc_r       <= '0;
        end else if (en) begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            r_r[i] <= vals[i*DATAW +: DATAW];
                        end
                        last_r <= in_last;
                        n_r    <= NW'(WIDTH);
                        cyc_r  <= '0;
                        if (out_count_r != 16'hFFFF) begin
                            out_count_r <= out_count_r + 16'd1;
                        end
                    end
                end
                FOLD: begin
                    r_r   <= r_next_s;
                    ovf_r <= ovf_r | fold_ovf_s;
                    if (layer_end_s) begin
                        n_r   <= pairs_s;
                        cyc_r <= '0;
                    end else begin
                        cyc_r <= cyc_r + {{(NW-1){1'b0}}, 1'b1};
                    end
                end
                ACC: begin
                    acc_r <= acc_add_s[DATAW-1:0];
                    ovf_r <= ovf_r | acc_add_s[DATAW];
                    if (last_r) begin
                        sum_r       <= acc_add_s[DATAW-1:0];
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        acc_r       <= '0;
                        out_count_r <= 16'd0;
                        ovf_r       <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fold_accumulator.sv
// Directed bench for fold_accumulator (WIDTH=16, DATAW=32, LANES=4).
// A wrapping and a saturating instance share all inputs.

module tb_fold_accumulator;

    localparam int WIDTH = 16;
    localparam int DATAW = 32;
    localparam int LANES = 4;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic                   in_valid;
    logic                   in_last;
    logic [DATAW*WIDTH-1:0] vals;
    logic                   out_ready;

    logic                   in_ready0, out_valid0, ovf0, busy0;
    logic [DATAW-1:0]       sum0;
    logic [15:0]            out_count0;
    logic                   in_ready1, out_valid1, ovf1, busy1;
    logic [DATAW-1:0]       sum1;
    logic [15:0]            out_count1;

    int checks;
    int fails;

    fold_accumulator #(.WIDTH(WIDTH), .DATAW(DATAW), .LANES(LANES), .SAT(0)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready0),
        .in_last(in_last), .vals(vals), .out_valid(out_valid0), .out_ready(out_ready),
        .sum(sum0), .out_count(out_count0), .ovf(ovf0), .busy(busy0)
    );

    fold_accumulator #(.WIDTH(WIDTH), .DATAW(DATAW), .LANES(LANES), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready1),
        .in_last(in_last), .vals(vals), .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .out_count(out_count1), .ovf(ovf1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input logic [DATAW-1:0] v);
        for (int i = 0; i < WIDTH; i++) vals[i*DATAW +: DATAW] = v;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < WIDTH; i++) vals[i*DATAW +: DATAW] = DATAW'(i + 1);
    endtask

    task automatic accept(input logic last);
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid0 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (in_ready0 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        fill_const(32'd0);
        tick(); tick();
        checks++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid0); end
        checks++; if (sum0 !== 32'd0) begin fails++; $display("FAIL rst_sum: got %0h expected 0", sum0); end
        checks++; if (out_count0 !== 16'd0) begin fails++; $display("FAIL rst_out_count: got %0d expected 0", out_count0); end
        checks++; if (ovf0 !== 1'b0 || busy0 !== 1'b0) begin fails++; $display("FAIL rst_ovf_busy: got %0b/%0b expected 0/0", ovf0, busy0); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready0); end
    endtask

    task automatic test_single();
        int lat;
        fill_ramp();
        accept(1'b1);
        checks++; if (busy0 !== 1'b1 || in_ready0 !== 1'b0) begin fails++; $display("FAIL t1_busy: got busy=%0b in_ready=%0b expected 1/0", busy0, in_ready0); end
        wait_valid(lat);
        checks++; if (lat != 6) begin fails++; $display("FAIL t1_latency: got %0d expected 6", lat); end
        checks++; if (sum0 !== 32'd136) begin fails++; $display("FAIL t1_sum: got %0d expected 136", sum0); end
        checks++; if (out_count0 !== 16'd1) begin fails++; $display("FAIL t1_out_count: got %0d expected 1", out_count0); end
        checks++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL t1_ovf: got %0b expected 0", ovf0); end
        handshake();
        checks++; if (out_valid0 !== 1'b0 || out_count0 !== 16'd0 || busy0 !== 1'b0) begin fails++; $display("FAIL t1_after_hs: got valid=%0b count=%0d busy=%0b expected 0/0/0", out_valid0, out_count0, busy0); end
    endtask

    task automatic test_burst();
        int lat;
        fill_const(32'd1);
        accept(1'b0);
        wait_ready(lat);
        checks++; if (lat != 6 || out_valid0 !== 1'b0) begin fails++; $display("FAIL t2_gap1: got lat=%0d valid=%0b expected 6/0", lat, out_valid0); end
        checks++; if (out_count0 !== 16'd1) begin fails++; $display("FAIL t2_count1: got %0d expected 1", out_count0); end
        fill_const(32'd2);
        accept(1'b0);
        wait_ready(lat);
        checks++; if (lat != 6 || out_valid0 !== 1'b0) begin fails++; $display("FAIL t2_gap2: got lat=%0d valid=%0b expected 6/0", lat, out_valid0); end
        fill_const(32'hFFFF_FFFF);
        accept(1'b1);
        wait_valid(lat);
        checks++; if (lat != 6) begin fails++; $display("FAIL t2_latency: got %0d expected 6", lat); end
        checks++; if (sum0 !== 32'd32) begin fails++; $display("FAIL t2_sum: got %0d expected 32", sum0); end
        checks++; if (out_count0 !== 16'd3) begin fails++; $display("FAIL t2_out_count: got %0d expected 3", out_count0); end
        checks++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL t2_ovf: got %0b expected 0", ovf0); end
        handshake();
    endtask

    task automatic test_overflow();
        int lat;
        fill_const(32'd0);
        vals[0*DATAW +: DATAW] = 32'h7FFF_FFFF;
        vals[1*DATAW +: DATAW] = 32'h7FFF_FFFF;
        accept(1'b1);
        wait_valid(lat);
        checks++; if (sum1 !== 32'h7FFF_FFFF) begin fails++; $display("FAIL t3_sat_sum: got %0h expected 7fffffff", sum1); end
        checks++; if (ovf1 !== 1'b1 || out_valid1 !== 1'b1) begin fails++; $display("FAIL t3_sat_ovf: got ovf=%0b valid=%0b expected 1/1", ovf1, out_valid1); end
        checks++; if (sum0 !== 32'hFFFF_FFFE) begin fails++; $display("FAIL t3_wrap_sum: got %0h expected fffffffe", sum0); end
        checks++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL t3_wrap_ovf: got %0b expected 1", ovf0); end
        handshake();
        checks++; if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin fails++; $display("FAIL t3_ovf_clear: got %0b/%0b expected 0/0", ovf0, ovf1); end
    endtask

    task automatic test_backpressure();
        int lat;
        fill_ramp();
        accept(1'b1);
        wait_valid(lat);
        in_valid = 1'b1;
        fill_const(32'd5);
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (out_valid0 !== 1'b1 || sum0 !== 32'd136 || in_ready0 !== 1'b0 || out_count0 !== 16'd1) begin
                fails++;
                $display("FAIL t4_hold%0d: got valid=%0b sum=%0d in_ready=%0b count=%0d expected 1/136/0/1", c, out_valid0, sum0, in_ready0, out_count0);
            end
        end
        in_valid = 1'b0;
        handshake();
        checks++; if (out_count0 !== 16'd0 || in_ready0 !== 1'b1) begin fails++; $display("FAIL t4_cleared: got count=%0d in_ready=%0b expected 0/1", out_count0, in_ready0); end
        fill_const(32'd1);
        accept(1'b1);
        wait_valid(lat);
        checks++; if (sum0 !== 32'd16 || out_count0 !== 16'd1) begin fails++; $display("FAIL t4_next_sum: got sum=%0d count=%0d expected 16/1", sum0, out_count0); end
        handshake();
    endtask

    task automatic test_enable();
        int edges;
        en = 1'b0;
        #1;
        checks++; if (in_ready0 !== 1'b0) begin fails++; $display("FAIL t5_ready_en0: got %0b expected 0", in_ready0); end
        en = 1'b1;
        fill_ramp();
        accept(1'b1);
        edges = 0;
        while (out_valid0 !== 1'b1 && edges < 40) begin
            en = 1'b0;
            tick();
            en = 1'b1;
            tick();
            edges++;
        end
        checks++; if (edges != 6) begin fails++; $display("FAIL t5_latency: got %0d expected 6", edges); end
        checks++; if (sum0 !== 32'd136) begin fails++; $display("FAIL t5_sum: got %0d expected 136", sum0); end
        en = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL t5_hs_en0: got %0b expected 1", out_valid0); end
        out_ready = 1'b0;
        en = 1'b1;
        handshake();
    endtask

    task automatic test_mid_reset();
        int lat;
        fill_const(32'd0);
        vals[0*DATAW +: DATAW] = 32'h7FFF_FFFF;
        vals[1*DATAW +: DATAW] = 32'h7FFF_FFFF;
        accept(1'b1);
        tick(); tick();
        checks++; if (busy0 !== 1'b1 || ovf0 !== 1'b1 || out_count0 !== 16'd1) begin fails++; $display("FAIL t6_pre: got busy=%0b ovf=%0b count=%0d expected 1/1/1", busy0, ovf0, out_count0); end
        #2 rst = 1'b0;
        #1;
        checks++; if (sum0 !== 32'd0 || out_count0 !== 16'd0) begin fails++; $display("FAIL t6_rst_sum_count: got %0h/%0d expected 0/0", sum0, out_count0); end
        checks++; if (ovf0 !== 1'b0 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin fails++; $display("FAIL t6_rst_flags: got ovf=%0b valid=%0b busy=%0b expected 0/0/0", ovf0, out_valid0, busy0); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL t6_ready: got %0b expected 1", in_ready0); end
        fill_const(32'd1);
        accept(1'b1);
        wait_valid(lat);
        checks++; if (lat != 6 || sum0 !== 32'd16 || out_count0 !== 16'd1) begin fails++; $display("FAIL t6_after: got lat=%0d sum=%0d count=%0d expected 6/16/1", lat, sum0, out_count0); end
        handshake();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_backpressure();
        test_enable();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fold_accumulator.md
Name: fold_accumulator

Overview:
- Parametrised integer reduction accumulator, successor to the fixed 16-input tree summer.
- Reduces a WIDTH-element vector to one value using LANES physical adders, time-multiplexed layer by layer.
- Adds each reduced vector into a running accumulator across a multi-vector burst, delimited by in_last.
- Valid/ready handshakes on input and output; optional signed saturation; sticky overflow flag.
- Sits between the multiply array and the result writeback in the BDPU datapath.

Parameters:
- WIDTH, 16: elements per input vector; power of 2, minimum 2.
- DATAW, 32: bits per element, accumulator and sum.
- LANES, 4: physical adders; power of 2, 1 to WIDTH/2.
- SAT, 0: 1 selects signed saturating adds; 0 selects two's-complement wrap.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous, active-low.
- en, input, 1: clock enable; when 0, all state holds.
- in_valid, input, 1: vals and in_last are valid.
- in_ready, output, 1: block accepts a vector this cycle.
- in_last, input, 1: marks the final vector of the burst.
- vals, input, DATAW*WIDTH: element i is at bits [(i+1)*DATAW-1 : i*DATAW].
- out_valid, output, 1: sum is valid.
- out_ready, input, 1: consumer takes the sum.
- sum, output, DATAW: burst total.
- out_count, output, 16: number of vectors accepted in the current burst.
- ovf, output, 1: sticky signed-overflow flag for the burst.
- busy, output, 1: high when state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, including mid-fold or mid-output):
  - state=IDLE, internal register file r[0..WIDTH-1]=0, acc=0.
  - sum=0, out_count=0, ovf=0, out_valid=0, busy=0.
- Enable:
  - All state updates require en=1.
  - in_ready = en & (state==IDLE).
  - The output handshake completes only when en=1.
- States: IDLE, FOLD, ACC, DONE.
- IDLE:
  - On in_valid & in_ready: r[i] <= element i; latch in_last; out_count <= out_count+1 (saturating at 16'hFFFF); go to FOLD.
- FOLD:
  - Active count n starts at WIDTH; each layer halves n until n=1.
  - A layer has p=n/2 pairs and takes ceil(p/LANES) cycles.
  - In layer cycle c, lane j (only when c*LANES+j < p): r[c*LANES+j] <= r[2k] + r[2k+1], where k=c*LANES+j. In-place update is safe.
  - Total fold cycles F = sum over layers of ceil(p/LANES). For WIDTH=16: LANES=4 gives F=5; LANES=1 gives F=15; LANES=8 gives F=4.
  - When n reaches 1, go to ACC.
- ACC, one cycle:
  - acc <= acc + r[0].
  - If the latched last bit is set: sum <= acc + r[0], out_valid <= 1, go to DONE.
  - Otherwise go to IDLE.
- Latency: out_valid rises F+1 enabled edges after the accepting edge of the last vector.
- DONE:
  - out_valid=1 and sum held stable until the handshake.
  - On out_valid & out_ready & en: out_valid <= 0, acc <= 0, out_count <= 0, ovf <= 0; go to IDLE.
  - in_ready stays low, so input and output never overlap.
- Arithmetic (applies to every fold add and the ACC add):
  - Signed overflow (operands same sign, result differs) sets ovf, sticky until the output handshake.
  - SAT=1: result clamps to 2^(DATAW-1)-1 or -2^(DATAW-1).
  - SAT=0: result wraps.
- en=0 mid-FOLD: layer and cycle counters freeze; resuming continues exactly where the fold stopped.
- An illegal state encoding goes to IDLE on the next enabled edge.

Test Plan:
1. WIDTH=16, LANES=4, element i = i+1, in_last=1, en=1 -> out_valid rises 6 edges after acceptance; sum=136; out_count=1; ovf=0.
2. Burst of three vectors (all 1s, all 2s, all -1s), last on the third -> single output with sum=32, out_count=3; in_ready high between vectors.
3. SAT=1, two elements 0x7FFFFFFF, the rest 0, last=1 -> sum=0x7FFFFFFF, ovf=1. Same stimulus with SAT=0 -> sum=0xFFFFFFFE, ovf=1.
4. Hold out_ready=0 for 10 cycles in DONE -> sum and out_valid stable and in_ready=0; after the handshake, acc and out_count are 0 and the next single vector of all 1s gives sum=16.
5. en toggled 0/1 every other cycle during FOLD -> same sum as scenario 1 (136); latency = 6 enabled edges.
6. rst driven low mid-FOLD, then released -> all outputs 0 immediately, state IDLE, in_ready=1 on the first enabled cycle after release.
